// File: rtl/key_spec_fifo.sv
// key_spec_fifo: QARMA key specialisation (enc/dec) feeding a DEPTH-entry FIFO.
// The four round keys are derived combinationally from the master key at the
// push side, and only the derived keys are stored.
// Optional feature macro: KEY_SPEC_ZEROIZE_EN. When it is defined, each popped
// entry is cleared, and the data outputs read 0 while the FIFO is empty.
module key_spec_fifo #(
    parameter int          N     = 128,
    parameter int          DEPTH = 2,
    parameter logic [127:0] ALPHA = 128'h243F6A8885A308D313198A2E03707344
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*N-1:0]           key,
    input  logic                     dec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             w0_o,
    output logic [N-1:0]             w1_o,
    output logic [N-1:0]             k0_o,
    output logic [N-1:0]             k1_o,
    output logic                     out_dec,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [N-1:0] w0;
        logic [N-1:0] w1;
        logic [N-1:0] k0;
        logic [N-1:0] k1;
        logic         dec;
    } entry_t;

    // Orthomorphism: rotate right by one, then fold the old MSB into bit 0.
    function automatic logic [N-1:0] ortho(input logic [N-1:0] x);
        ortho = {x[0], x[N-1:2], x[1] ^ x[N-1]};
    endfunction

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    entry_t          new_e;
    entry_t          head;
    logic            push, pop;

    // Handshake flags come from registered occupancy only.
    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Derive the round keys for the entry offered at the input.
    always_comb begin
        logic [N-1:0] w0_in, k0_in;
        w0_in = key[2*N-1:N];
        k0_in = key[N-1:0];
        new_e = '0;
        if (!dec) begin
            new_e.w0  = w0_in;
            new_e.w1  = ortho(w0_in);
            new_e.k0  = k0_in;
            new_e.k1  = k0_in;
            new_e.dec = 1'b0;
        end else begin
            new_e.w0  = ortho(w0_in);
            new_e.w1  = w0_in;
            new_e.k0  = k0_in ^ ALPHA[N-1:0];
            new_e.k1  = k0_in;
            new_e.dec = 1'b1;
        end
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
`ifdef KEY_SPEC_ZEROIZE_EN
        // Push and pop never target the same slot: that needs level 0 or full.
        if (pop) mem_d[rd_ptr_q] = '0;
`endif
        if (push) begin
            mem_d[wr_ptr_q] = new_e;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers; reset discards all entries and clears storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Head entry is read straight from storage.
    always_comb begin
`ifdef KEY_SPEC_ZEROIZE_EN
        head = out_valid ? mem_q[rd_ptr_q] : '0;
`else
        head = mem_q[rd_ptr_q];
`endif
    end

    assign w0_o    = head.w0;
    assign w1_o    = head.w1;
    assign k0_o    = head.k0;
    assign k1_o    = head.k1;
    assign out_dec = head.dec;

endmodule
